// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter.
// Holds the FSM state encoding, bus widths and the default grant hold limit.
// Imported by the picker, the interface and the arbiter top.
package rr_arb_pkg;

   localparam int N_REQ        = 16;  // requesters; equals the downstream encoder input width
   localparam int IDX_W        = 4;   // winner index / rotation pointer width
   localparam int HOLD_MAX_DEF = 8;   // default maximum grant length in cycles (0 = no timeout)

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Ports: i_enable, i_req[15:0], i_release toward the arbiter; o_grant16[15:0],
//        o_grant_valid, o_timeout (and o_grant_idx[3:0] when RR_ARB_IDX_EN) from it.
// The master modport is the arbiter side; slave is the requester/encoder side.
interface rr_arbiter_16_if;
   import rr_arb_pkg::*;

   logic              i_enable;
   logic [N_REQ-1:0]  i_req;
   logic              i_release;
   logic [N_REQ-1:0]  o_grant16;
   logic              o_grant_valid;
   logic              o_timeout;
`ifdef RR_ARB_IDX_EN
   logic [IDX_W-1:0]  o_grant_idx;
`endif

   modport master (
      input  i_enable, i_req, i_release,
      output o_grant16, o_grant_valid, o_timeout
`ifdef RR_ARB_IDX_EN
      , output o_grant_idx
`endif
   );

   modport slave (
      output i_enable, i_req, i_release,
      input  o_grant16, o_grant_valid, o_timeout
`ifdef RR_ARB_IDX_EN
      , input o_grant_idx
`endif
   );

endinterface

// File: rtl/rr_pick_16.sv
// Combinational rotate-priority picker: first set request above the pointer wins.
// Ports: i_req[15:0], i_pointer[3:0] -> o_hit, o_winner[3:0], o_onehot[15:0].
// Zero latency; no flow control. Search order is pointer+1 .. pointer (mod 16).
module rr_pick_16
   import rr_arb_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_pointer,
   output logic             o_hit,
   output logic [IDX_W-1:0] o_winner,
   output logic [N_REQ-1:0] o_onehot
);

   logic [IDX_W-1:0] w_idx;

   always_comb begin
      o_hit    = 1'b0;
      o_winner = '0;
      w_idx    = '0;
      // k = 16 wraps the 4-bit sum back to the pointer itself, so the last
      // winner is checked last.
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx = i_pointer + IDX_W'(k);
         if (!o_hit && i_req[w_idx]) begin
            o_hit    = 1'b1;
            o_winner = w_idx;
         end
      end
      o_onehot = o_hit ? (N_REQ'(1) << o_winner) : '0;
   end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter, 16 requesters, registered one-hot grant feeding a 16:4 encoder.
// Ports: clk, reset (sync, active-high), arb (rr_arbiter_16_if.master).
// Latency: req sampled in IDLE -> grant one cycle later. Each grant is followed by a
// one-cycle GAP, so grants are separated by >= 2 zero cycles. Optional macro
// RR_ARB_IDX_EN adds o_grant_idx, the registered binary winner index.
module rr_arbiter_16
   import rr_arb_pkg::*;
#(
   parameter int HOLD_MAX = HOLD_MAX_DEF
)(
   input  logic            clk,
   input  logic            reset,
   rr_arbiter_16_if.master arb
);

   // Counter value seen on the last cycle of a maximal grant.
   localparam logic [IDX_W-1:0] HOLD_LAST = IDX_W'(HOLD_MAX - 1);

   state_t            r_state;
   logic [N_REQ-1:0]  r_grant16;
   logic              r_grant_valid;
   logic              r_timeout;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  r_cnt;
`ifdef RR_ARB_IDX_EN
   logic [IDX_W-1:0]  r_grant_idx;
`endif

   logic              w_hit;
   logic [IDX_W-1:0]  w_winner;
   logic [N_REQ-1:0]  w_onehot;
   logic              w_req_held;
   logic              w_expired;
   logic              w_exit;
   logic              w_timeout;

   rr_pick_16 u_pick (
      .i_req     (arb.i_req),
      .i_pointer (r_ptr),
      .o_hit     (w_hit),
      .o_winner  (w_winner),
      .o_onehot  (w_onehot)
   );

   // r_grant16 is one-hot during GRANT, so masking req with it tests req[winner].
   assign w_req_held = |(arb.i_req & r_grant16);
   assign w_expired  = (HOLD_MAX != 0) && (r_cnt == HOLD_LAST);
   assign w_exit     = !arb.i_enable || arb.i_release || !w_req_held || w_expired;
   // Timeout is flagged only when expiry is the sole reason the grant ends.
   assign w_timeout  = arb.i_enable && !arb.i_release && w_req_held && w_expired;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_grant16     <= '0;
         r_grant_valid <= 1'b0;
         r_timeout     <= 1'b0;
         r_ptr         <= IDX_W'(N_REQ - 1);  // first search starts at requester 0
         r_cnt         <= '0;
`ifdef RR_ARB_IDX_EN
         r_grant_idx   <= '0;
`endif
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (arb.i_enable && w_hit) begin
                  r_grant16     <= w_onehot;
                  r_grant_valid <= 1'b1;
                  r_ptr         <= w_winner;
                  r_cnt         <= '0;
`ifdef RR_ARB_IDX_EN
                  r_grant_idx   <= w_winner;
`endif
                  r_state       <= GRANT;
               end
            end
            GRANT: begin
               if (w_exit) begin
                  r_grant16     <= '0;
                  r_grant_valid <= 1'b0;
                  r_timeout     <= w_timeout;
                  r_state       <= GAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            GAP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign arb.o_grant16     = r_grant16;
   assign arb.o_grant_valid = r_grant_valid;
   assign arb.o_timeout     = r_timeout;
`ifdef RR_ARB_IDX_EN
   assign arb.o_grant_idx   = r_grant_idx;
`endif

endmodule
